// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, byte-enabled writes.
// Optional macro DMEM_MMIO_EN adds a halt register at 32'hFFFF_FFF0 (store sets halt, load reads
// halt_code). Memory is never reset; a simulation harness may preload `mem` externally.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // 33 bits so BASE+4*DEPTH cannot wrap in the range compare
    localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LatCnt   = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          st_q, st_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ready_q;
    logic            we_q;
    logic [31:0]     addr_q, wdata_q;
    logic [3:0]      be_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept, enter_resp;
    logic            acc_we;
    logic [31:0]     acc_addr, acc_wdata;
    logic [3:0]      acc_be;
    logic [31:0]     offset;
    logic            in_range, is_mmio, acc_err;
    logic [IdxW-1:0] idx;

    assign req_ready = ready_q;
    assign rsp_valid = (st_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid & ready_q;

    // With zero wait states RESP is entered on the accept edge, so decode the live request then.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (st_q == StIdle) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    // Address decode: aligned, at or above base, and offset inside the array (no aliasing on wrap).
    always_comb begin
        offset   = acc_addr - BASE_ADDR;
        in_range = (acc_addr[1:0] == 2'b00) && (acc_addr >= BASE_ADDR) &&
                   ({1'b0, offset} < MemBytes);
        idx      = offset[IdxW+1:2];
        acc_err  = !in_range && !is_mmio;
    end

    // Next-state logic; enter_resp marks the single edge where the access takes effect.
    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        st_d       = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        st_d  = StWait;
                        cnt_d = LatCnt;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    st_d       = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    // State, request capture and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            // Registered so ready drops during reset and reappears one cycle after it.
            ready_q <= (st_d == StIdle);
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (enter_resp) begin
                err_q <= acc_err;
                if (acc_err || acc_we) rdata_q <= '0;
                else if (is_mmio)      rdata_q <= halt_code;
                else                   rdata_q <= mem[idx];
            end
        end
    end

    // Store commit on RESP entry only; a reset before then discards the store.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && acc_we && !acc_err && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MMIO_EN
    localparam logic [31:0] HaltAddr = 32'hFFFF_FFF0;

    assign is_mmio = (acc_addr == HaltAddr);

    // Halt register: sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt      <= 1'b0;
            halt_code <= '0;
        end else if (enter_resp && is_mmio && acc_we) begin
            halt      <= 1'b1;
            halt_code <= acc_wdata;
        end
    end
`else
    assign is_mmio   = 1'b0;
    assign halt      = 1'b0;
    assign halt_code = '0;
`endif

endmodule
